store_checker: RTL

Synthesizable, parametrised checker that monitors the data-memory write port of the single-cycle core and decides pass/fail against a programmed sequence of expected stores. It generalises the fixed "address 84 gets 7, address 80 is scratch" check into a loadable table of DEPTH ordered (address, data) entries, with a scratch-address filter, a cycle timeout and registered status outputs. It sits beside `top` in simulation and FPGA bring-up, driven by the same clock and the core's write_enab, data_addr and write_data nets.

---
 rtl/store_checker_if.sv | 34 +++
 rtl/store_checker.sv | 137 +++++++++++++
 2 files changed

// File: rtl/store_checker_if.sv
// Bundle of the checker's table-load, core store-port and status signals.
// The core side (bench or SoC glue) uses master; the checker uses slave.
interface store_checker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic              write_enab;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] write_data;
  logic              done;
  logic              pass;
  logic [1:0]        status;
  logic [CntW-1:0]   match_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [31:0]       cycle_count;

  modport master (
    output load_en, load_addr, load_data, start, write_enab, data_addr, write_data,
    input  done, pass, status, match_count, fail_addr, fail_data, cycle_count
  );

  modport slave (
    input  load_en, load_addr, load_data, start, write_enab, data_addr, write_data,
    output done, pass, status, match_count, fail_addr, fail_data, cycle_count
  );
endinterface

// File: rtl/store_checker.sv
// Watches the core's data-memory write port and checks it against a loaded, ordered table
// of expected (address, data) stores, with a scratch-address filter and a cycle timeout.
module store_checker #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 4,
  parameter bit                IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = 80,
  parameter int unsigned       TIMEOUT     = 100
) (
  input logic            clk,
  input logic            reset_n,
  store_checker_if.slave bus
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StRun, StPass, StMismatch, StTimeout} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [DATA_W-1:0] tbl_data_q [DEPTH];
  logic [CntW-1:0]   num_q;
  logic [CntW-1:0]   match_q;
  logic [31:0]       cyc_q;
  logic [1:0]        status_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              load_ok, can_start, counted, hit, miss, last_hit, timed_out;
  logic [31:0]       cyc_next;

  // Entry under test; match count doubles as the table index.
  always_comb begin
    exp_addr = '0;
    exp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_q == CntW'(i)) begin
        exp_addr = tbl_addr_q[i];
        exp_data = tbl_data_q[i];
      end
    end
  end

  assign load_ok   = bus.load_en && (num_q != CntW'(DEPTH));
  assign can_start = bus.start && ((num_q != '0) || load_ok);
  assign counted   = bus.write_enab && !(IGNORE_EN && (bus.data_addr == IGNORE_ADDR));
  assign hit       = counted && (bus.data_addr == exp_addr) && (bus.write_data == exp_data);
  assign miss      = counted && !hit;
  assign last_hit  = hit && ((match_q + 1'b1) == num_q);
  assign cyc_next  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
  assign timed_out = cyc_next >= 32'(TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      match_q     <= '0;
      cyc_q       <= '0;
      status_q    <= 2'b00;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (load_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (num_q == CntW'(i)) begin
                tbl_addr_q[i] <= bus.load_addr;
                tbl_data_q[i] <= bus.load_data;
              end
            end
            num_q <= num_q + 1'b1;
          end
          if (can_start) begin
            state_q <= StRun;
            match_q <= '0;
            cyc_q   <= '0;
          end
        end
        StRun: begin
          cyc_q <= cyc_next;
          // Mismatch and final match both take priority over the timeout.
          if (miss) begin
            state_q     <= StMismatch;
            status_q    <= 2'b10;
            done_q      <= 1'b1;
            fail_addr_q <= bus.data_addr;
            fail_data_q <= bus.write_data;
          end else if (last_hit) begin
            match_q  <= match_q + 1'b1;
            state_q  <= StPass;
            status_q <= 2'b01;
            done_q   <= 1'b1;
            pass_q   <= 1'b1;
          end else begin
            if (hit) match_q <= match_q + 1'b1;
            if (timed_out) begin
              state_q  <= StTimeout;
              status_q <= 2'b11;
              done_q   <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_q     <= StRun;
            match_q     <= '0;
            cyc_q       <= '0;
            status_q    <= 2'b00;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.status      = status_q;
  assign bus.match_count = match_q;
  assign bus.fail_addr   = fail_addr_q;
  assign bus.fail_data   = fail_data_q;
  assign bus.cycle_count = cyc_q;
endmodule
